// File: rtl/ntt_pkg.sv
// Shared Kyber NTT constants, Barrett reduction, inverse-NTT zeta ROM and FSM state type.
package ntt_pkg;

    localparam int COEFF_WIDTH   = 12;
    localparam int KYBER_N       = 256;
    localparam int KYBER_Q       = 3329;
    localparam int INTT_SCALE    = 3303;
    localparam int BARRETT_SHIFT = 24;
    localparam int BARRETT_MUL   = 5039;
    localparam int INTT_DRAIN    = 3;
    localparam int PROD_W        = 2 * COEFF_WIDTH;
    localparam int BARRETT_W     = PROD_W + 13;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_DRAIN,
        ST_UNLOAD
    } intt_state_e;

    // Two adjacent coefficients share one array word; len >= 2 keeps both in the same block.
    typedef logic [1:0][COEFF_WIDTH-1:0] coeff_pair_t;

    localparam logic [COEFF_WIDTH-1:0] ZETAS [128] = '{
        12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
        12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
        12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
        12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
        12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
        12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
        12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
        12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
        12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
        12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
        12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
        12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
        12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
        12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
        12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
        12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
    };

    function automatic logic [COEFF_WIDTH-1:0] zeta_rom(input logic [6:0] idx);
        return ZETAS[idx];
    endfunction

    // Estimate is at most one q short for x < 2^24, so a single correction suffices.
    function automatic logic [COEFF_WIDTH-1:0] barrett_reduce(input logic [PROD_W-1:0] x);
        logic [BARRETT_W-1:0] prod;
        logic [PROD_W-1:0]    qest;
        logic [PROD_W-1:0]    rem;
        prod = BARRETT_W'(x) * BARRETT_W'(BARRETT_MUL);
        qest = PROD_W'(prod >> BARRETT_SHIFT);
        rem  = x - qest * PROD_W'(KYBER_Q);
        if (rem >= PROD_W'(KYBER_Q))
            rem = rem - PROD_W'(KYBER_Q);
        return COEFF_WIDTH'(rem);
    endfunction

endpackage

// File: rtl/kyber_gs_butterfly.sv
// Three-stage Gentleman-Sande butterfly operating on two coefficient lanes that share one zeta.
module kyber_gs_butterfly
    import ntt_pkg::*;
#(
    parameter int COEFF_WIDTH = ntt_pkg::COEFF_WIDTH,
    parameter int WADDR_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   issue,
    input  logic [WADDR_W-1:0]     a_idx,
    input  logic [WADDR_W-1:0]     b_idx,
    input  coeff_pair_t            a_data,
    input  coeff_pair_t            b_data,
    input  logic [COEFF_WIDTH-1:0] zeta,
    output logic                   wr_en,
    output logic [WADDR_W-1:0]     wr_a_idx,
    output logic [WADDR_W-1:0]     wr_b_idx,
    output coeff_pair_t            wr_a_data,
    output coeff_pair_t            wr_b_data
);

    localparam int SUM_W = COEFF_WIDTH + 1;
    localparam logic [SUM_W-1:0] Q_EXT = SUM_W'(KYBER_Q);

    function automatic logic [COEFF_WIDTH-1:0] mod_add(input logic [COEFF_WIDTH-1:0] a,
                                                       input logic [COEFF_WIDTH-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= Q_EXT)
            s = s - Q_EXT;
        return COEFF_WIDTH'(s);
    endfunction

    // b - a + q stays non-negative; fold back to canonical before the 12x12 multiply.
    function automatic logic [COEFF_WIDTH-1:0] mod_sub(input logic [COEFF_WIDTH-1:0] b,
                                                       input logic [COEFF_WIDTH-1:0] a);
        logic [SUM_W-1:0] d;
        d = {1'b0, b} + Q_EXT - {1'b0, a};
        if (d >= Q_EXT)
            d = d - Q_EXT;
        return COEFF_WIDTH'(d);
    endfunction

    logic                   vld_p0, vld_p1;
    coeff_pair_t            a_p0, b_p0, sum_p1, diff_p1;
    logic [COEFF_WIDTH-1:0] zeta_p0, zeta_p1;
    logic [WADDR_W-1:0]     a_idx_p0, b_idx_p0, a_idx_p1, b_idx_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
        end
    end

    // p0: operand read register
    always_ff @(posedge clk) begin
        if (issue) begin
            a_p0     <= a_data;
            b_p0     <= b_data;
            zeta_p0  <= zeta;
            a_idx_p0 <= a_idx;
            b_idx_p0 <= b_idx;
        end
    end

    // p1: modular add / subtract
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            for (int l = 0; l < 2; l++) begin
                sum_p1[l]  <= mod_add(a_p0[l], b_p0[l]);
                diff_p1[l] <= mod_sub(b_p0[l], a_p0[l]);
            end
            zeta_p1  <= zeta_p0;
            a_idx_p1 <= a_idx_p0;
            b_idx_p1 <= b_idx_p0;
        end
    end

    // p2: multiply + Barrett, written back by the array on the next edge
    always_comb begin
        wr_b_data = '0;
        for (int l = 0; l < 2; l++)
            wr_b_data[l] = barrett_reduce(PROD_W'(diff_p1[l]) * PROD_W'(zeta_p1));
    end

    assign wr_en     = vld_p1;
    assign wr_a_idx  = a_idx_p1;
    assign wr_b_idx  = b_idx_p1;
    assign wr_a_data = sum_p1;

endmodule

// File: rtl/kyber_intt.sv
// Iterative Kyber inverse NTT: stream in 256 coefficients, 7 GS layers, stream out in order.
// Define KYBER_INTT_SCALE_EN to multiply each output by 128^-1 mod q (true inverse NTT).
module kyber_intt
    import ntt_pkg::*;
#(
    parameter int COEFF_WIDTH = ntt_pkg::COEFF_WIDTH,
    parameter int KYBER_N     = ntt_pkg::KYBER_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COEFF_WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COEFF_WIDTH-1:0] out_data,
    output logic                   busy
);

    localparam int ADDR_W  = $clog2(KYBER_N);
    localparam int WORDS   = KYBER_N / 2;
    localparam int WADDR_W = $clog2(WORDS);

    intt_state_e state, state_nxt;

    coeff_pair_t mem [WORDS];

    logic [ADDR_W-1:0]  load_cnt;
    logic [5:0]         issue_cnt;
    logic [1:0]         drain_cnt;
    logic [2:0]         layer;
    logic [6:0]         zeta_idx;
    logic [ADDR_W:0]    rd_idx;
    logic [ADDR_W-1:0]  out_cnt;

    logic accept, last_load, last_issue, drain_done, last_layer;
    logic block_end, unload_adv, out_hs, last_out;

    logic [WADDR_W-1:0] wlen, wmask, k_ext, wa_idx, wb_idx;

    logic                   bf_wr_en;
    logic [WADDR_W-1:0]     bf_wr_a_idx, bf_wr_b_idx;
    coeff_pair_t            bf_wr_a_data, bf_wr_b_data;

    logic [COEFF_WIDTH-1:0] rd_data_p0;
    logic                   rd_vld_p0;
    logic [COEFF_WIDTH-1:0] out_next;

    assign in_ready   = (state == ST_LOAD);
    assign busy       = (state != ST_LOAD);
    assign accept     = in_valid && in_ready;
    assign last_load  = accept && (load_cnt == ADDR_W'(KYBER_N - 1));
    assign last_issue = (state == ST_COMPUTE) && (issue_cnt == 6'd63);
    assign drain_done = (state == ST_DRAIN) && (drain_cnt == 2'(INTT_DRAIN - 1));
    assign last_layer = (layer == 3'd6);
    assign unload_adv = !out_valid || out_ready;
    assign out_hs     = (state == ST_UNLOAD) && out_valid && out_ready;
    assign last_out   = out_hs && (out_cnt == ADDR_W'(KYBER_N - 1));

    // Issue k maps to word pair (wa, wa + len/2) inside block k / (len/2).
    assign wlen      = WADDR_W'(1) << layer;
    assign wmask     = wlen - 1'b1;
    assign k_ext     = WADDR_W'(issue_cnt);
    assign wa_idx    = ((k_ext & ~wmask) << 1) | (k_ext & wmask);
    assign wb_idx    = wa_idx | wlen;
    assign block_end = ((k_ext & wmask) == wmask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:    if (last_load)  state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (last_issue) state_nxt = ST_DRAIN;
            ST_DRAIN:   if (drain_done) state_nxt = last_layer ? ST_UNLOAD : ST_COMPUTE;
            ST_UNLOAD:  if (last_out)   state_nxt = ST_LOAD;
            default:                    state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= '0;
            issue_cnt <= '0;
            drain_cnt <= '0;
            layer     <= '0;
            zeta_idx  <= '0;
            rd_idx    <= '0;
            out_cnt   <= '0;
        end else begin
            if (accept)
                load_cnt <= load_cnt + 1'b1;
            case (state)
                ST_LOAD: begin
                    issue_cnt <= '0;
                    drain_cnt <= '0;
                    layer     <= '0;
                    zeta_idx  <= 7'd127;
                    rd_idx    <= '0;
                    out_cnt   <= '0;
                end
                ST_COMPUTE: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (block_end)
                        zeta_idx <= zeta_idx - 1'b1;
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        drain_cnt <= '0;
                        layer     <= layer + 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (unload_adv && !rd_idx[ADDR_W])
                        rd_idx <= rd_idx + 1'b1;
                    if (out_hs)
                        out_cnt <= out_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[load_cnt[ADDR_W-1:1]][load_cnt[0]] <= in_data;
        if (bf_wr_en) begin
            mem[bf_wr_a_idx] <= bf_wr_a_data;
            mem[bf_wr_b_idx] <= bf_wr_b_data;
        end
    end

    kyber_gs_butterfly #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .WADDR_W     (WADDR_W)
    ) u_bfly (
        .clk       (clk),
        .rst_n     (rst_n),
        .issue     (state == ST_COMPUTE),
        .a_idx     (wa_idx),
        .b_idx     (wb_idx),
        .a_data    (mem[wa_idx]),
        .b_data    (mem[wb_idx]),
        .zeta      (zeta_rom(zeta_idx)),
        .wr_en     (bf_wr_en),
        .wr_a_idx  (bf_wr_a_idx),
        .wr_b_idx  (bf_wr_b_idx),
        .wr_a_data (bf_wr_a_data),
        .wr_b_data (bf_wr_b_data)
    );

`ifdef KYBER_INTT_SCALE_EN
    assign out_next = barrett_reduce(PROD_W'(rd_data_p0) * PROD_W'(INTT_SCALE));
`else
    assign out_next = rd_data_p0;
`endif

    // p0: array read register; the whole two-stage output pipe stalls as one unit
    always_ff @(posedge clk) begin
        if (state == ST_UNLOAD && unload_adv)
            rd_data_p0 <= mem[rd_idx[ADDR_W-1:1]][rd_idx[0]];
    end

    // p1: out_data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_p0 <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (state == ST_UNLOAD) begin
            if (unload_adv) begin
                rd_vld_p0 <= !rd_idx[ADDR_W];
                out_valid <= rd_vld_p0;
                if (rd_vld_p0)
                    out_data <= out_next;
            end
        end else begin
            rd_vld_p0 <= 1'b0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kyber_intt.sv
// Scoreboard bench for kyber_intt against a FIPS 203 Algorithm 10 reference model.
`timescale 1ns/1ps
module tb_kyber_intt;

    localparam int Q = 3329;
`ifdef KYBER_INTT_SCALE_EN
    localparam bit SCALE_EN = 1'b1;
`else
    localparam bit SCALE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] in_data = '0;
    logic        in_ready, out_valid, busy;
    logic [11:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];
    int vec[256];

    always #5 clk = ~clk;

    kyber_intt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic int bitrev7(input int x);
        int r = 0;
        for (int b = 0; b < 7; b++)
            if ((x >> b) & 1) r |= 1 << (6 - b);
        return r;
    endfunction

    function automatic int zeta_of(input int i);
        int r = 1;
        int e = bitrev7(i);
        for (int k = 0; k < e; k++) r = (r * 17) % Q;
        return r;
    endfunction

    task automatic push_model();
        int f[256];
        int zi, z, t;
        f = vec;
        zi = 127;
        for (int len = 2; len <= 128; len = len * 2) begin
            for (int start = 0; start < 256; start = start + 2 * len) begin
                z = zeta_of(zi);
                zi--;
                for (int j = start; j < start + len; j++) begin
                    t = f[j];
                    f[j] = (t + f[j + len]) % Q;
                    f[j + len] = (z * ((f[j + len] - t + Q) % Q)) % Q;
                end
            end
        end
        for (int n = 0; n < 256; n++)
            exp_q.push_back(SCALE_EN ? (f[n] * 3303) % Q : f[n]);
    endtask

    task automatic load_vec();
        int guard;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_data  = 12'(vec[i]);
            guard = 0;
            while (!in_ready && guard < 10) begin
                @(posedge clk); #1; guard++;
            end
            if (guard >= 10) begin
                n_tests++; n_fail++;
                $display("FAIL load_timeout idx=%0d in_ready=%0b required=1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_first_valid(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
        end
        if (!out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL first_valid_timeout out_valid=0 required=1 within 1000 cycles");
        end
    endtask

    task automatic drain_out(input int stall_pct, input string name);
        int          hs_cnt, guard, exp;
        logic        ov, prev_stall;
        logic [11:0] od, prev_d;
        bit          rdy;
        hs_cnt = 0; guard = 0; prev_stall = 1'b0; prev_d = '0;
        while (hs_cnt < 256 && guard < 5000) begin
            ov = out_valid;
            od = out_data;
            if (prev_stall) begin
                n_tests++;
                if (!ov || od !== prev_d) begin
                    n_fail++;
                    $display("FAIL %s_stall_hold idx=%0d valid=%0b data=%0d required valid=1 data=%0d",
                             name, hs_cnt, ov, od, prev_d);
                end
            end
            rdy = ($urandom_range(0, 99) >= stall_pct);
            out_ready = rdy;
            @(posedge clk); #1; guard++;
            if (ov && rdy) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                n_tests++;
                if (exp < 0 || od !== 12'(exp)) begin
                    n_fail++;
                    $display("FAIL %s_data idx=%0d got=%0d required=%0d", name, hs_cnt, od, exp);
                end
                hs_cnt++;
                if (hs_cnt == 255) begin
                    n_tests++;
                    if (in_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s_early_ready in_ready=%0b required=0", name, in_ready);
                    end
                end
            end
            prev_stall = ov && !rdy;
            prev_d = od;
        end
        out_ready = 1'b0;
        n_tests++;
        if (hs_cnt != 256 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end handshakes=%0d in_ready=%0b busy=%0b out_valid=%0b required 256/1/0/0",
                     name, hs_cnt, in_ready, busy, out_valid);
        end
    endtask

    task automatic run_full(input int stall_pct, input string name);
        int cyc;
        push_model();
        load_vec();
        wait_first_valid(cyc);
        drain_out(stall_pct, name);
    endtask

    task automatic randomize_vec();
        for (int i = 0; i < 256; i++) vec[i] = $urandom_range(0, Q - 1);
    endtask

    task automatic abort_checks(input string name);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s in_ready=%0b out_valid=%0b busy=%0b required 1/0/0",
                     name, in_ready, out_valid, busy);
        end
        exp_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b required=1", in_ready); end
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b required=0", out_valid); end
        n_tests++;
        if (out_data !== 12'd0) begin n_fail++; $display("FAIL reset_out_data got=%0d required=0", out_data); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b required=0", busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zeros();
        int cyc;
        for (int i = 0; i < 256; i++) vec[i] = 0;
        push_model();
        load_vec();
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zeros_after_load in_ready=%0b busy=%0b required 0/1", in_ready, busy);
        end
        wait_first_valid(cyc);
        n_tests++;
        if (cyc != 471) begin
            n_fail++;
            $display("FAIL zeros_latency got=%0d required=471", cyc);
        end
        drain_out(0, "zeros");
    endtask

    task automatic test_alternating();
        int cyc;
        for (int i = 0; i < 256; i++) vec[i] = (i % 2 == 0) ? 1 : 0;
        exp_q.push_back(SCALE_EN ? 1 : 128);
        for (int i = 1; i < 256; i++) exp_q.push_back(0);
        load_vec();
        wait_first_valid(cyc);
        drain_out(0, "alternating");
    endtask

    task automatic test_neg_one();
        int cyc;
        for (int i = 0; i < 256; i++) vec[i] = (i % 2 == 0) ? Q - 1 : 0;
        exp_q.push_back(SCALE_EN ? Q - 1 : Q - 128);
        for (int i = 1; i < 256; i++) exp_q.push_back(0);
        load_vec();
        wait_first_valid(cyc);
        drain_out(0, "neg_one");
    endtask

    task automatic test_random();
        for (int v = 0; v < 12; v++) begin
            randomize_vec();
            run_full(0, "random");
        end
    endtask

    task automatic test_back_to_back_stall();
        for (int v = 0; v < 2; v++) begin
            randomize_vec();
            run_full(30, "backpressure");
        end
    endtask

    task automatic test_reset_compute();
        int seen;
        randomize_vec();
        load_vec();
        repeat (100) @(posedge clk);
        #1;
        abort_checks("reset_compute");
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_tests++;
        if (seen != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_compute_quiet valid_cycles=%0d busy=%0b required 0/0", seen, busy);
        end
        randomize_vec();
        run_full(0, "after_reset_compute");
    endtask

    task automatic test_reset_unload();
        int cyc, hs, guard, exp;
        logic [11:0] od;
        randomize_vec();
        push_model();
        load_vec();
        wait_first_valid(cyc);
        hs = 0; guard = 0;
        out_ready = 1'b1;
        while (hs < 50 && guard < 1000) begin
            od = out_data;
            if (out_valid) begin
                @(posedge clk); #1;
                exp = exp_q.pop_front();
                n_tests++;
                if (od !== 12'(exp)) begin
                    n_fail++;
                    $display("FAIL reset_unload_data idx=%0d got=%0d required=%0d", hs, od, exp);
                end
                hs++;
            end else begin
                @(posedge clk); #1;
            end
            guard++;
        end
        out_ready = 1'b0;
        abort_checks("reset_unload");
        n_tests++;
        if (hs != 50) begin
            n_fail++;
            $display("FAIL reset_unload_count handshakes=%0d required=50", hs);
        end
        randomize_vec();
        run_full(0, "after_reset_unload");
    endtask

    initial begin
        test_reset();
        test_zeros();
        test_alternating();
        test_neg_one();
        test_random();
        test_back_to_back_stall();
        test_reset_compute();
        test_reset_unload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
